tx_scrambler_stage: RTL and testbench

// - TX byte scrambler, 4 symbols/word, PCIe Gen1/2 (8b/10b) lane path.
// - Sits directly downstream of the 16-bit scrambler LFSR keystream generator.
// - XORs D-symbols with the keystream, passes K-symbols and ordered sets clear,
//   and drives the LFSR's scrambler_reset on COM. Feeds the 8b/10b encoder.

---
 rtl/tx_scrambler_stage.sv | 96 +++++++++
 tb/tb_tx_scrambler_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/tx_scrambler_stage.sv
// TX byte scrambler stage: XORs D-symbols with the LFSR keystream, passes K-symbols and ordered sets clear.
// Optional misaligned-COM checker enabled by defining SCR_OS_CHECK_EN.
module tx_scrambler_stage #(
  parameter logic [7:0] COM_SYM  = 8'hBC,
  parameter logic [7:0] SKP_SYM  = 8'h1C,
  parameter int         TS_WORDS = 4
) (
  input  logic                        pclk,
  input  logic                        reset_n,
  input  logic [31:0]                 in_data,
  input  logic [3:0]                  in_datak,
  input  logic                        disable_scrambling,
  input  logic [31:0]                 lfsr_data,
  output logic                        scrambler_reset,
  output logic [31:0]                 out_data,
  output logic [3:0]                  out_datak,
  output logic                        out_os,
  output logic                        os_err,
  output logic                        out_skp,
  output logic [$clog2(TS_WORDS)-1:0] os_cnt_dbg
);

  localparam int CNT_W = $clog2(TS_WORDS);

  logic             com_hit;
  logic             one_word_os;
  logic             os_word;
  logic             skp_word;
  logic [CNT_W-1:0] os_cnt;
  logic [CNT_W-1:0] os_cnt_nxt;
  logic [31:0]      data_nxt;

  assign com_hit         = in_datak[0] && (in_data[7:0] == COM_SYM);
  assign one_word_os     = &in_datak[3:1];
  assign scrambler_reset = com_hit && reset_n;
  assign skp_word        = com_hit && one_word_os && (in_data[15:8] == SKP_SYM);
  assign os_cnt_dbg      = os_cnt;

  // A COM always restarts classification, even in the middle of a TS.
  always_comb begin
    os_cnt_nxt = os_cnt;
    os_word    = 1'b0;
    if (com_hit) begin
      os_word    = 1'b1;
      os_cnt_nxt = one_word_os ? '0 : CNT_W'(TS_WORDS - 1);
    end else if (os_cnt != '0) begin
      os_word    = 1'b1;
      os_cnt_nxt = os_cnt - 1'b1;
    end
  end

  // The keystream byte is always consumed; only the XOR is gated.
  always_comb begin
    data_nxt = in_data;
    for (int n = 0; n < 4; n++) begin
      if (!os_word && !disable_scrambling && !in_datak[n])
        data_nxt[8*n +: 8] = in_data[8*n +: 8] ^ lfsr_data[8*n +: 8];
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      os_cnt    <= '0;
      out_data  <= '0;
      out_datak <= '0;
      out_os    <= 1'b0;
      out_skp   <= 1'b0;
    end else begin
      os_cnt    <= os_cnt_nxt;
      out_data  <= data_nxt;
      out_datak <= in_datak;
      out_os    <= os_word;
      out_skp   <= skp_word;
    end
  end

`ifdef SCR_OS_CHECK_EN
  logic misaligned_com;

  always_comb begin
    misaligned_com = 1'b0;
    for (int n = 1; n < 4; n++) begin
      if (in_datak[n] && (in_data[8*n +: 8] == COM_SYM))
        misaligned_com = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) os_err <= 1'b0;
    else          os_err <= os_err | misaligned_com;
  end
`else
  assign os_err = 1'b0;
`endif

endmodule

// File: tb/tb_tx_scrambler_stage.sv
// Bench for tx_scrambler_stage: table of words with hand-computed results, scoreboard queue,
// plus a hand-written asynchronous-reset-mid-TS sequence.
module tb_tx_scrambler_stage;

  logic        pclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_datak = '0;
  logic        disable_scrambling = 1'b0;
  logic [31:0] lfsr_data = '0;
  logic        scrambler_reset;
  logic [31:0] out_data;
  logic [3:0]  out_datak;
  logic        out_os;
  logic        os_err;
  logic        out_skp;
  logic [1:0]  os_cnt_dbg;

  int checks = 0;
  int failures = 0;

  tx_scrambler_stage dut (
    .pclk(pclk), .reset_n(reset_n), .in_data(in_data), .in_datak(in_datak),
    .disable_scrambling(disable_scrambling), .lfsr_data(lfsr_data),
    .scrambler_reset(scrambler_reset), .out_data(out_data), .out_datak(out_datak),
    .out_os(out_os), .os_err(os_err), .out_skp(out_skp), .os_cnt_dbg(os_cnt_dbg)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] in_data;
    logic [3:0]  in_datak;
    logic        dis;
    logic [31:0] lfsr;
    logic [31:0] exp_data;
    logic        exp_os;
    logic        exp_srst;
    logic        exp_skp;
    logic [1:0]  exp_cnt;
  } vec_t;

  vec_t vecs[21];
  // {data, datak, os, skp, cnt}
  logic [39:0] exp_q[$];
  logic        exp_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [39:0] e;
    @(negedge pclk);
    in_data = v.in_data;
    in_datak = v.in_datak;
    disable_scrambling = v.dis;
    lfsr_data = v.lfsr;
    #1;
    check($sformatf("srst[%0d]", idx), 64'(scrambler_reset), 64'(v.exp_srst));
    exp_q.push_back({v.exp_data, v.in_datak, v.exp_os, v.exp_skp, v.exp_cnt});
`ifdef SCR_OS_CHECK_EN
    for (int n = 1; n < 4; n++)
      if (v.in_datak[n] && v.in_data[8*n +: 8] == 8'hBC) exp_err = 1'b1;
`endif
    @(posedge pclk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("out_data[%0d]", idx), 64'(out_data), 64'(e[39:8]));
    check($sformatf("out_datak[%0d]", idx), 64'(out_datak), 64'(e[7:4]));
    check($sformatf("out_os[%0d]", idx), 64'(out_os), 64'(e[3]));
    check($sformatf("out_skp[%0d]", idx), 64'(out_skp), 64'(e[2]));
    check($sformatf("os_cnt[%0d]", idx), 64'(os_cnt_dbg), 64'(e[1:0]));
    check($sformatf("os_err[%0d]", idx), 64'(os_err), 64'(exp_err));
  endtask

  initial begin
    //            in_data       k        dis   lfsr          exp_data      os    srst  skp   cnt
    vecs[0]  = '{32'h00000000, 4'b0000, 1'b0, 32'h14C017FF, 32'h14C017FF, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{32'h1C1C1CBC, 4'b1111, 1'b0, 32'h12345678, 32'h1C1C1CBC, 1'b1, 1'b1, 1'b1, 2'd0};
    vecs[2]  = '{32'h11223344, 4'b0000, 1'b0, 32'hFFFFFFFF, 32'hEEDDCCBB, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[3]  = '{32'h4A4A00BC, 4'b0001, 1'b0, 32'hAAAAAAAA, 32'h4A4A00BC, 1'b1, 1'b1, 1'b0, 2'd3};
    vecs[4]  = '{32'h4A4A4A4A, 4'b0000, 1'b0, 32'h55555555, 32'h4A4A4A4A, 1'b1, 1'b0, 1'b0, 2'd2};
    vecs[5]  = '{32'h4A4A4A4A, 4'b0000, 1'b0, 32'h0F0F0F0F, 32'h4A4A4A4A, 1'b1, 1'b0, 1'b0, 2'd1};
    vecs[6]  = '{32'h4A4A4A4A, 4'b0000, 1'b0, 32'hF0F0F0F0, 32'h4A4A4A4A, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[7]  = '{32'h4A4A4A4A, 4'b0000, 1'b0, 32'h0F0F0F0F, 32'h45454545, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[8]  = '{32'hAA00FBAA, 4'b0010, 1'b0, 32'h0F0F0F0F, 32'hA50FFBA5, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[9]  = '{32'h12345678, 4'b0000, 1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[10] = '{32'h1C1C1CBC, 4'b1111, 1'b1, 32'hFFFFFFFF, 32'h1C1C1CBC, 1'b1, 1'b1, 1'b1, 2'd0};
    vecs[11] = '{32'h00F7F7BC, 4'b0011, 1'b1, 32'hFFFFFFFF, 32'h00F7F7BC, 1'b1, 1'b1, 1'b0, 2'd3};
    vecs[12] = '{32'h01020304, 4'b0000, 1'b0, 32'hFFFFFFFF, 32'h01020304, 1'b1, 1'b0, 1'b0, 2'd2};
    vecs[13] = '{32'h000000BC, 4'b0001, 1'b0, 32'hFFFFFFFF, 32'h000000BC, 1'b1, 1'b1, 1'b0, 2'd3};
    vecs[14] = '{32'h00000000, 4'b0000, 1'b0, 32'h11111111, 32'h00000000, 1'b1, 1'b0, 1'b0, 2'd2};
    vecs[15] = '{32'h00000000, 4'b0000, 1'b0, 32'h11111111, 32'h00000000, 1'b1, 1'b0, 1'b0, 2'd1};
    vecs[16] = '{32'h00000000, 4'b0000, 1'b0, 32'h11111111, 32'h00000000, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[17] = '{32'h00000000, 4'b0000, 1'b0, 32'h22222222, 32'h22222222, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[18] = '{32'h5C5C5CFB, 4'b0001, 1'b0, 32'hFFFFFFFF, 32'hA3A3A3FB, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[19] = '{32'h000000BC, 4'b0000, 1'b0, 32'h00000001, 32'h000000BD, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[20] = '{32'h00BC0000, 4'b0100, 1'b0, 32'hFFFFFFFF, 32'hFFBCFFFF, 1'b0, 1'b0, 1'b0, 2'd0};

    // Reset state, with a COM on the input to confirm scrambler_reset is held low.
    in_data = 32'h000000BC;
    in_datak = 4'b0001;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_out_datak", 64'(out_datak), 64'h0);
    check("rst_out_os", 64'(out_os), 64'h0);
    check("rst_os_err", 64'(os_err), 64'h0);
    check("rst_os_cnt", 64'(os_cnt_dbg), 64'h0);
    check("rst_srst", 64'(scrambler_reset), 64'h0);
    @(negedge pclk);
    in_data = '0;
    in_datak = '0;
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) apply(vecs[i], i);

    // Asynchronous reset in the middle of a TS.
    @(negedge pclk);
    reset_n = 1'b1;
    in_data = 32'h4A4A00BC;
    in_datak = 4'b0001;
    disable_scrambling = 1'b0;
    lfsr_data = 32'hFFFFFFFF;
    @(negedge pclk);
    in_data = 32'h4A4A4A4A;
    in_datak = 4'b0000;
    @(posedge pclk);
    #1;
    check("mid_ts_os", 64'(out_os), 64'h1);
    check("mid_ts_cnt", 64'(os_cnt_dbg), 64'd2);
    #2;
    in_data = 32'h000000BC;
    in_datak = 4'b0001;
    reset_n = 1'b0;
    #1;
    check("arst_out_os", 64'(out_os), 64'h0);
    check("arst_out_data", 64'(out_data), 64'h0);
    check("arst_cnt", 64'(os_cnt_dbg), 64'h0);
    check("arst_os_err", 64'(os_err), 64'h0);
    check("arst_srst", 64'(scrambler_reset), 64'h0);
    @(negedge pclk);
    reset_n = 1'b1;
    in_data = 32'h00000000;
    in_datak = 4'b0000;
    lfsr_data = 32'h33333333;
    @(posedge pclk);
    #1;
    check("post_rst_data", 64'(out_data), 64'h33333333);
    check("post_rst_os", 64'(out_os), 64'h0);
    check("post_rst_cnt", 64'(os_cnt_dbg), 64'h0);

    if (exp_q.size() != 0) check("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
